// File: rtl/multimode_ff_bank_if.sv
// Bus bundle for multimode_ff_bank: control/data inputs and the registered
// state, complement, change and SR-error outputs.
interface multimode_ff_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       mode;
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sclr;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_b;
    logic [WIDTH-1:0] changed;
    logic             sr_err;
    logic [WIDTH-1:0] err_bits;

    modport master (
        output mode, en, a, b, sclr, err_clr,
        input  q, q_b, changed, sr_err, err_bits
    );

    modport slave (
        input  mode, en, a, b, sclr, err_clr,
        output q, q_b, changed, sr_err, err_bits
    );
endinterface

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit flip-flop bank whose bits act as SR, JK, D or T flops (shared mode),
// with per-bit enables, synchronous clear, change flags and sticky SR-error capture.
module multimode_ff_bank #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int unsigned      SR_ILLEGAL = 0
) (
    input logic                clk,
    input logic                rst_n,
    multimode_ff_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic             sr_err_q, sr_err_d;
    logic [WIDTH-1:0] err_hit;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        q_d     = q_q;
        err_hit = '0;
        if (bus.sclr) begin
            q_d = RESET_VAL;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.en[i]) begin
                    unique case (mode)
                        MODE_SR: begin
                            unique case ({bus.a[i], bus.b[i]})
                                2'b01:   q_d[i] = 1'b0;
                                2'b10:   q_d[i] = 1'b1;
                                2'b11: begin
                                    // Error is flagged even when the policy resolves the value.
                                    err_hit[i] = 1'b1;
                                    if (SR_ILLEGAL == 1)      q_d[i] = 1'b0;
                                    else if (SR_ILLEGAL == 2) q_d[i] = 1'b1;
                                end
                                default: q_d[i] = q_q[i];
                            endcase
                        end
                        MODE_JK: begin
                            unique case ({bus.a[i], bus.b[i]})
                                2'b01:   q_d[i] = 1'b0;
                                2'b10:   q_d[i] = 1'b1;
                                2'b11:   q_d[i] = ~q_q[i];
                                default: q_d[i] = q_q[i];
                            endcase
                        end
                        MODE_D:  q_d[i] = bus.a[i];
                        MODE_T:  q_d[i] = q_q[i] ^ bus.a[i];
                        default: q_d[i] = q_q[i];
                    endcase
                end
            end
        end
    end

    always_comb begin
        changed_d  = q_d ^ q_q;
        sr_err_d   = sr_err_q;
        err_bits_d = err_bits_q;
        // A fresh error at the same edge as err_clr replaces the old record.
        if (|err_hit) begin
            sr_err_d   = 1'b1;
            err_bits_d = bus.err_clr ? err_hit : (err_bits_q | err_hit);
        end else if (bus.err_clr) begin
            sr_err_d   = 1'b0;
            err_bits_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= RESET_VAL;
            changed_q  <= '0;
            sr_err_q   <= 1'b0;
            err_bits_q <= '0;
        end else begin
            q_q        <= q_d;
            changed_q  <= changed_d;
            sr_err_q   <= sr_err_d;
            err_bits_q <= err_bits_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.q_b      = ~q_q;
    assign bus.changed  = changed_q;
    assign bus.sr_err   = sr_err_q;
    assign bus.err_bits = err_bits_q;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed table plus corner sequences and a random run for multimode_ff_bank,
// covering all three SR illegal-input policies, a non-zero reset value and WIDTH=1.
module tb_multimode_ff_bank;
  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_JK = 2'b01;
  localparam logic [1:0] M_D  = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multimode_ff_bank_if #(.WIDTH(8)) if0 ();
  multimode_ff_bank_if #(.WIDTH(8)) if1 ();
  multimode_ff_bank_if #(.WIDTH(8)) if2 ();
  multimode_ff_bank_if #(.WIDTH(1)) if3 ();

  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_ILLEGAL(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h3C), .SR_ILLEGAL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_ILLEGAL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  multimode_ff_bank #(.WIDTH(1), .RESET_VAL(1'b0),  .SR_ILLEGAL(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // Reference model: characteristic equations per instance, inputs masked to width.
  int         m_ill  [4] = '{0, 1, 2, 0};
  logic [7:0] m_rv   [4] = '{8'h00, 8'h3C, 8'h00, 8'h00};
  logic [7:0] m_mask [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h01};
  logic [7:0] m_q  [4];
  logic [7:0] m_ch [4];
  logic [7:0] m_eb [4];
  logic       m_err[4];

  logic [1:0] cur_mode;
  logic [7:0] cur_en, cur_a, cur_b;
  logic       cur_sclr, cur_ec;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] en;
    logic [7:0] a;
    logic [7:0] b;
    logic       sclr;
    logic [7:0] exp_q;
    logic [7:0] exp_ch;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_q[k]   = m_rv[k] & m_mask[k];
      m_ch[k]  = 8'h00;
      m_eb[k]  = 8'h00;
      m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [7:0] e, a, b, q, nx, fill, nq, hit;
    for (int k = 0; k < 4; k++) begin
      e = cur_en & m_mask[k];
      a = cur_a & m_mask[k];
      b = cur_b & m_mask[k];
      q = m_q[k];
      fill = (m_ill[k] == 0) ? q : (m_ill[k] == 1) ? 8'h00 : 8'hFF;
      case (cur_mode)
        M_SR:    nx = (a & ~b) | (q & ~a & ~b) | (a & b & fill);
        M_JK:    nx = (a & ~q) | (~b & q);
        M_D:     nx = a;
        default: nx = q ^ a;
      endcase
      nq  = cur_sclr ? m_rv[k] : ((nx & e) | (q & ~e));
      nq  = nq & m_mask[k];
      hit = (cur_mode == M_SR && !cur_sclr) ? (e & a & b) : 8'h00;
      m_eb[k]  = (cur_ec ? 8'h00 : m_eb[k]) | hit;
      m_err[k] = (m_err[k] & ~cur_ec) | (|hit);
      m_ch[k]  = nq ^ q;
      m_q[k]   = nq;
    end
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s u0.q", tag), if0.q, m_q[0]);
    check($sformatf("%s u0.q_b", tag), if0.q_b, ~m_q[0]);
    check($sformatf("%s u0.changed", tag), if0.changed, m_ch[0]);
    check($sformatf("%s u0.sr_err", tag), {7'b0, if0.sr_err}, {7'b0, m_err[0]});
    check($sformatf("%s u0.err_bits", tag), if0.err_bits, m_eb[0]);
    check($sformatf("%s u1.q", tag), if1.q, m_q[1]);
    check($sformatf("%s u1.q_b", tag), if1.q_b, ~m_q[1]);
    check($sformatf("%s u1.changed", tag), if1.changed, m_ch[1]);
    check($sformatf("%s u1.sr_err", tag), {7'b0, if1.sr_err}, {7'b0, m_err[1]});
    check($sformatf("%s u1.err_bits", tag), if1.err_bits, m_eb[1]);
    check($sformatf("%s u2.q", tag), if2.q, m_q[2]);
    check($sformatf("%s u2.changed", tag), if2.changed, m_ch[2]);
    check($sformatf("%s u2.sr_err", tag), {7'b0, if2.sr_err}, {7'b0, m_err[2]});
    check($sformatf("%s u2.err_bits", tag), if2.err_bits, m_eb[2]);
    check($sformatf("%s u3.q", tag), {7'b0, if3.q}, m_q[3]);
    check($sformatf("%s u3.q_b", tag), {7'b0, if3.q_b}, {7'b0, ~m_q[3][0]});
    check($sformatf("%s u3.changed", tag), {7'b0, if3.changed}, m_ch[3]);
    check($sformatf("%s u3.sr_err", tag), {7'b0, if3.sr_err}, {7'b0, m_err[3]});
    check($sformatf("%s u3.err_bits", tag), {7'b0, if3.err_bits}, m_eb[3]);
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] e, input logic [7:0] a,
                       input logic [7:0] b, input logic s, input logic ec);
    cur_mode = m; cur_en = e; cur_a = a; cur_b = b; cur_sclr = s; cur_ec = ec;
    if0.mode = m; if0.en = e; if0.a = a; if0.b = b; if0.sclr = s; if0.err_clr = ec;
    if1.mode = m; if1.en = e; if1.a = a; if1.b = b; if1.sclr = s; if1.err_clr = ec;
    if2.mode = m; if2.en = e; if2.a = a; if2.b = b; if2.sclr = s; if2.err_clr = ec;
    if3.mode = m; if3.en = e[0]; if3.a = a[0]; if3.b = b[0]; if3.sclr = s; if3.err_clr = ec;
  endtask

  task automatic apply(input string tag, input logic [1:0] m, input logic [7:0] e,
                       input logic [7:0] a, input logic [7:0] b, input logic s, input logic ec);
    drive(m, e, a, b, s, ec);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    // JK / D / T / sclr / SR table for u0 (RESET_VAL=0), starting from q=00.
    tbl[0]  = '{M_JK, 8'hFF, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'hF0};
    tbl[1]  = '{M_JK, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h0F, 8'hFF};
    tbl[2]  = '{M_JK, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h00};
    tbl[3]  = '{M_D,  8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'h0F};
    tbl[4]  = '{M_D,  8'h0F, 8'hFF, 8'h00, 1'b0, 8'h0F, 8'h0F};
    tbl[5]  = '{M_T,  8'h0F, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h0F};
    tbl[6]  = '{M_T,  8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{M_D,  8'hFF, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'hA5};
    tbl[8]  = '{M_D,  8'hFF, 8'hFF, 8'h00, 1'b1, 8'h00, 8'hA5};
    tbl[9]  = '{M_SR, 8'hFF, 8'hF0, 8'h00, 1'b0, 8'hF0, 8'hF0};
    tbl[10] = '{M_SR, 8'hFF, 8'h00, 8'h30, 1'b0, 8'hC0, 8'h30};
    tbl[11] = '{M_SR, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hC0, 8'h00};
    tbl[12] = '{M_JK, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h3F, 8'hFF};

    drive(M_D, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("por");
    check("por u1.q reset value", if1.q, 8'h3C);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release with en=0: nothing moves, changed stays low.
    apply("release", M_D, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    check("release u1.changed", if1.changed, 8'h00);

    for (int i = 0; i < 13; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].sclr, 1'b0);
      check($sformatf("tbl%0d q", i), if0.q, tbl[i].exp_q);
      check($sformatf("tbl%0d changed", i), if0.changed, tbl[i].exp_ch);
    end

    // SR illegal input under all three policies, then err_clr racing a new error.
    apply("sr_load", M_D, 8'hFF, 8'h55, 8'h00, 1'b0, 1'b0);
    apply("sr_ill", M_SR, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0);
    check("sr_ill u0.q", if0.q, 8'h55);
    check("sr_ill u1.q", if1.q, 8'h54);
    check("sr_ill u2.q", if2.q, 8'h55);
    check("sr_ill u0.sr_err", {7'b0, if0.sr_err}, 8'h01);
    check("sr_ill u1.err_bits", if1.err_bits, 8'h01);
    apply("sr_race", M_SR, 8'hFF, 8'h04, 8'h04, 1'b0, 1'b1);
    check("sr_race u0.err_bits", if0.err_bits, 8'h04);
    check("sr_race u1.q", if1.q, 8'h50);
    check("sr_race u2.sr_err", {7'b0, if2.sr_err}, 8'h01);
    check("sr_race u3.sr_err", {7'b0, if3.sr_err}, 8'h00);
    apply("sr_clr", M_SR, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    check("sr_clr u0.sr_err", {7'b0, if0.sr_err}, 8'h00);
    check("sr_clr u0.err_bits", if0.err_bits, 8'h00);
    // Disabled bit, sclr cycle and D mode must not raise an error.
    apply("sr_dis", M_SR, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0);
    check("sr_dis u0.sr_err", {7'b0, if0.sr_err}, 8'h00);
    apply("sr_sclr", M_SR, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    check("sr_sclr u1.q", if1.q, 8'h3C);
    check("sr_sclr u2.sr_err", {7'b0, if2.sr_err}, 8'h00);
    apply("d_ab", M_D, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check("d_ab u0.sr_err", {7'b0, if0.sr_err}, 8'h00);
    apply("sr_ill2", M_SR, 8'h81, 8'h81, 8'h81, 1'b0, 1'b0);
    check("sr_ill2 u0.err_bits", if0.err_bits, 8'h81);

    // Asynchronous reset asserted mid-cycle with q=A5.
    apply("pre_rst", M_D, 8'hFF, 8'hA5, 8'h00, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst u0.q", if0.q, 8'h00);
    check("async_rst u0.sr_err", {7'b0, if0.sr_err}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    compare_all("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply("release2", M_T, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    check("release2 u0.changed", if0.changed, 8'h00);

    // Random traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      apply("rnd", 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
